// File: rtl/any1_icache_fill_if.sv
// Memory-bus side of the I-cache line fill: cycle/strobe read, per-beat ack or error.
// The fill engine is the master; the memory system is the slave.
interface any1_icache_fill_if #(
    parameter int AMSB = 63
);
    logic            cyc_o;
    logic            stb_o;
    logic [AMSB:0]   adr_o;
    logic            ack_i;
    logic            err_i;
    logic [127:0]    dat_i;

    modport master (output cyc_o, stb_o, adr_o, input ack_i, err_i, dat_i);
    modport slave  (input cyc_o, stb_o, adr_o, output ack_i, err_i, dat_i);
endinterface

// File: rtl/any1_icache_fill.sv
// L1 I-cache line fill: 4x128-bit bus beats into one 512-bit line, then wr + nxt to the cache.
// Miss to wr is 5 cycles with zero-wait acks; the bus stalls via ack_i, errors/timeouts become fault bits.
module any1_icache_fill #(
    parameter int AMSB = 63,
    parameter int TMO  = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    any1_icache_fill_if.master    bus,
    input  logic                  miss,
    input  logic [AMSB:0]         missadr,
    input  logic                  abort,
    output logic                  busy,
    output logic                  wr,
    output logic [AMSB:0]         wadr,
    output logic [511:0]          dat_o,
    output logic [2:0]            fault_o,
    output logic                  nxt
);
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, WAIT1, WAIT2} state_t;

    state_t      state;
    logic [1:0]  beat;
    logic [7:0]  tmo_cnt;
    logic [1:0]  beat_inc;
    logic [7:0]  tmo_inc;
    logic        tmo_hit;
    logic        unused_missadr_lo;

    assign beat_inc = beat + 2'd1;
    assign tmo_inc  = tmo_cnt + 8'd1;
    assign tmo_hit  = (tmo_inc == 8'(TMO));
    assign unused_missadr_lo = ^missadr[5:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            beat      <= 2'd0;
            tmo_cnt   <= 8'd0;
            busy      <= 1'b0;
            bus.cyc_o <= 1'b0;
            bus.stb_o <= 1'b0;
            bus.adr_o <= '0;
            wr        <= 1'b0;
            wadr      <= '0;
            dat_o     <= '0;
            fault_o   <= 3'b000;
            nxt       <= 1'b0;
        end else begin
            wr  <= 1'b0;
            nxt <= 1'b0;
            case (state)
                IDLE: begin
                    if (miss && !abort) begin
                        wadr      <= {missadr[AMSB:6], 6'b0};
                        bus.adr_o <= {missadr[AMSB:6], 6'b0};
                        beat      <= 2'd0;
                        tmo_cnt   <= 8'd0;
                        fault_o   <= 3'b000;
                        bus.cyc_o <= 1'b1;
                        bus.stb_o <= 1'b1;
                        busy      <= 1'b1;
                        state     <= FETCH;
                    end
                end
                FETCH: begin
                    if (abort) begin
                        bus.cyc_o <= 1'b0;
                        bus.stb_o <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (bus.err_i || (!bus.ack_i && tmo_hit)) begin
                        // Error wins over a same-cycle ack; unfilled slices must not leak stale data.
                        fault_o[0] <= bus.err_i;
                        fault_o[1] <= !bus.err_i;
                        if (!bus.err_i)
                            tmo_cnt <= tmo_inc;
                        for (int s = 0; s < 4; s++)
                            if (s >= int'(beat))
                                dat_o[128*s +: 128] <= '0;
                        bus.cyc_o <= 1'b0;
                        bus.stb_o <= 1'b0;
                        wr        <= 1'b1;
                        state     <= WRITE;
                    end else if (bus.ack_i) begin
                        dat_o[128*beat +: 128] <= bus.dat_i;
                        tmo_cnt <= 8'd0;
                        if (beat == 2'd3) begin
                            bus.cyc_o <= 1'b0;
                            bus.stb_o <= 1'b0;
                            wr        <= 1'b1;
                            state     <= WRITE;
                        end else begin
                            beat      <= beat_inc;
                            bus.adr_o <= wadr | {{(AMSB-5){1'b0}}, beat_inc, 4'h0};
                        end
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                WRITE: begin
                    nxt   <= 1'b1;
                    state <= WAIT1;
                end
                // Gives the cache's delayed data-RAM write a cycle before miss is looked at again.
                WAIT1: state <= WAIT2;
                WAIT2: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
